// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline constants, AXI encodings and the fetch FSM state type.
package cpu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned SIZE_W = 3;
   localparam int unsigned BR_W   = 2;

   // BranchCtrl encodings; 2'b11 is reserved and behaves like PC4
   localparam logic [BR_W-1:0] PC4    = 2'b00;
   localparam logic [BR_W-1:0] PCIMM  = 2'b01;
   localparam logic [BR_W-1:0] IMMRS1 = 2'b10;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [1:0]        BURST_INCR = 2'b01;
   localparam logic [SIZE_W-1:0] SIZE_WORD  = 3'b010;
   localparam logic [1:0]        RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DATA = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

   // Read-address channel payload
   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [XLEN-1:0]   addr;
      logic [LEN_W-1:0]  len;
      logic [SIZE_W-1:0] size;
      logic [1:0]        burst;
   } ar_req_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: sequential, branch/JAL target or JALR target.
module pc_next_sel
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] pc_i,
   input  logic [BR_W-1:0] branch_ctrl_i,
   input  logic [XLEN-1:0] pc_imm_i,
   input  logic [XLEN-1:0] imm_rs1_i,
   output logic [XLEN-1:0] next_pc_c_o
);

   // Select the redirect target; the reserved encoding falls through to pc+4
   always_comb begin
      next_pc_c_o = pc_i + XLEN'(4);
      case (branch_ctrl_i)
         PCIMM:   next_pc_c_o = pc_imm_i;
         IMMRS1:  next_pc_c_o = imm_rs1_i & ~XLEN'(1);
         default: next_pc_c_o = pc_i + XLEN'(4);
      endcase
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one single-beat AXI4 read per
// instruction and presents the fetched word to IF/ID with a stall flag.
module if_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [ID_W-1:0] AXI_ID    = 4'h0,
   parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              pc_write,
   input  logic [BR_W-1:0]   branch_ctrl,
   input  logic [XLEN-1:0]   pc_imm,
   input  logic [XLEN-1:0]   imm_rs1,
   output logic [XLEN-1:0]   instr_out,
   output logic [XLEN-1:0]   pc_out,
   output logic              IM_stall,
   output logic [ID_W-1:0]   ARID,
   output logic [XLEN-1:0]   ARADDR,
   output logic [LEN_W-1:0]  ARLEN,
   output logic [SIZE_W-1:0] ARSIZE,
   output logic [1:0]        ARBURST,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [ID_W-1:0]   RID,
   input  logic [XLEN-1:0]   RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_buf_q, instr_buf_d;
   logic [XLEN-1:0] next_pc;
   logic            arvalid_q, arvalid_d;
   logic            rready_q, rready_d;
   logic            im_stall_q, im_stall_d;
   logic            r_hit;
   ar_req_t         ar_req;

   pc_next_sel u_pc_next_sel (
      .pc_i          (pc_q),
      .branch_ctrl_i (branch_ctrl),
      .pc_imm_i      (pc_imm),
      .imm_rs1_i     (imm_rs1),
      .next_pc_c_o   (next_pc)
   );

   // Final beat of our own transaction; foreign-ID beats are drained and dropped
   assign r_hit = RVALID && RLAST && (RID == AXI_ID);

   // FSM state register
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath update; redirect only accepted while holding a word
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_buf_d = instr_buf_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (arvalid_q && ARREADY) state_d = S_DATA;
         end
         S_DATA: begin
            if (r_hit) begin
               state_d     = S_HOLD;
               instr_buf_d = (RRESP == RESP_OKAY) ? RDATA : NOP_INSTR;
            end
         end
         S_HOLD: begin
            if (pc_write) begin
               state_d = S_REQ;
               pc_d    = next_pc;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the registered flags track the state
   always_comb begin
      arvalid_d  = 1'b0;
      rready_d   = 1'b0;
      im_stall_d = 1'b1;
      case (state_d)
         S_REQ:   arvalid_d  = 1'b1;
         S_DATA:  rready_d   = 1'b1;
         S_HOLD:  im_stall_d = 1'b0;
         default: im_stall_d = 1'b1;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         pc_q        <= RESET_PC;
         instr_buf_q <= NOP_INSTR;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         im_stall_q  <= 1'b1;
      end else begin
         pc_q        <= pc_d;
         instr_buf_q <= instr_buf_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         im_stall_q  <= im_stall_d;
      end
   end

   assign ar_req = '{id: AXI_ID, addr: pc_q, len: '0, size: SIZE_WORD, burst: BURST_INCR};

   assign ARID      = ar_req.id;
   assign ARADDR    = ar_req.addr;
   assign ARLEN     = ar_req.len;
   assign ARSIZE    = ar_req.size;
   assign ARBURST   = ar_req.burst;
   assign ARVALID   = arvalid_q;
   assign RREADY    = rready_q;
   assign IM_stall  = im_stall_q;
   assign instr_out = instr_buf_q;
   assign pc_out    = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: AXI slave driver plus a PC/instruction reference model.
module tb_if_fetch_unit;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        pc_write = 1'b0;
   logic [1:0]  branch_ctrl = 2'b00;
   logic [31:0] pc_imm = 32'h0;
   logic [31:0] imm_rs1 = 32'h0;
   logic [31:0] instr_out, pc_out;
   logic        IM_stall;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY = 1'b0;
   logic [3:0]  RID = 4'h0;
   logic [31:0] RDATA = 32'h0;
   logic [1:0]  RRESP = 2'b00;
   logic        RLAST = 1'b0;
   logic        RVALID = 1'b0;
   logic        RREADY;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_pc    = 32'h0;
   logic [31:0] exp_instr = 32'h13;

   if_fetch_unit dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .pc_write(pc_write), .branch_ctrl(branch_ctrl),
      .pc_imm(pc_imm), .imm_rs1(imm_rs1), .instr_out(instr_out), .pc_out(pc_out),
      .IM_stall(IM_stall), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA),
      .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Architectural next-PC rule
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] bc,
                                              input logic [31:0] imm, input logic [31:0] rs1);
      if (bc == 2'd1) return imm;
      if (bc == 2'd2) return rs1 - (rs1 % 32'd2);
      return pc + 32'd4;
   endfunction

   // Request a redirect/advance from S_HOLD and update the model PC
   task automatic advance(input logic [1:0] bc, input logic [31:0] imm, input logic [31:0] rs1);
      pc_write = 1'b1; branch_ctrl = bc; pc_imm = imm; imm_rs1 = rs1;
      @(negedge ACLK);
      pc_write = 1'b0; branch_ctrl = 2'($urandom); pc_imm = $urandom; imm_rs1 = $urandom;
      exp_pc = model_next(exp_pc, bc, imm, rs1);
   endtask

   // Act as the IM slave for one fetch; ends at the negedge after the data beat
   task automatic serve_fetch(input int ar_dly, input int r_dly, input int junk,
                              input logic [31:0] data, input logic [1:0] resp,
                              output logic [31:0] addr, output int waited, output bit hs_ok);
      waited = 0;
      hs_ok  = 1'b1;
      while (ARVALID !== 1'b1 && waited < 20) begin
         @(negedge ACLK);
         waited++;
      end
      if (waited >= 20) hs_ok = 1'b0;
      addr = ARADDR;
      for (int i = 0; i < ar_dly; i++) begin
         ARREADY = 1'b0; pc_write = 1'($urandom); branch_ctrl = 2'($urandom);
         @(negedge ACLK);
         if (ARVALID !== 1'b1 || ARADDR !== addr || IM_stall !== 1'b1) hs_ok = 1'b0;
      end
      ARREADY = 1'b1; pc_write = 1'($urandom);
      @(negedge ACLK);
      ARREADY = 1'b0;
      if (RREADY !== 1'b1 || ARVALID !== 1'b0 || IM_stall !== 1'b1) hs_ok = 1'b0;
      for (int i = 0; i < junk; i++) begin
         RVALID = 1'b1; RID = 4'($urandom_range(1, 15)); RLAST = 1'b1;
         RDATA = $urandom; RRESP = 2'b00; pc_write = 1'($urandom);
         @(negedge ACLK);
         if (IM_stall !== 1'b1 || RREADY !== 1'b1) hs_ok = 1'b0;
      end
      RVALID = 1'b0;
      for (int i = 0; i < r_dly; i++) begin
         pc_write = 1'($urandom);
         @(negedge ACLK);
         if (IM_stall !== 1'b1 || RREADY !== 1'b1) hs_ok = 1'b0;
      end
      RVALID = 1'b1; RID = 4'h0; RLAST = 1'b1; RDATA = data; RRESP = resp;
      @(negedge ACLK);
      RVALID = 1'b0; RLAST = 1'b0; pc_write = 1'b0;
      exp_instr = (resp == 2'b00) ? data : 32'h0000_0013;
   endtask

   task automatic test_reset();
      ARESETn = 1'b0; ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1; pc_write = 1'b1;
      repeat (3) @(negedge ACLK);
      checks++; if (ARVALID !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", ARVALID); end
      checks++; if (RREADY !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", RREADY); end
      checks++; if (IM_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", IM_stall); end
      checks++; if (instr_out !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h want 00000013", instr_out); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc_out); end
      ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; pc_write = 1'b0;
      exp_pc = 32'h0; exp_instr = 32'h13;
   endtask

   task automatic test_first_fetch();
      logic [31:0] addr; int waited; bit ok;
      ARESETn = 1'b1;
      @(negedge ACLK);
      checks++; if (ARVALID !== 1'b1 || ARADDR !== 32'h0) begin errors++; $display("FAIL first_ar: got valid=%b addr=%h want valid=1 addr=00000000", ARVALID, ARADDR); end
      checks++; if ({ARID, ARLEN, ARSIZE, ARBURST} !== {4'h0, 4'h0, 3'b010, 2'b01}) begin errors++; $display("FAIL ar_const: got id=%h len=%h size=%b burst=%b", ARID, ARLEN, ARSIZE, ARBURST); end
      serve_fetch(0, 0, 0, 32'h0000_0093, 2'b00, addr, waited, ok);
      checks++; if (waited !== 0 || !ok) begin errors++; $display("FAIL first_hs: got waited=%0d ok=%0d want 0/1", waited, ok); end
      checks++; if (IM_stall !== 1'b0) begin errors++; $display("FAIL first_stall: got %b want 0", IM_stall); end
      checks++; if (instr_out !== 32'h93 || pc_out !== 32'h0) begin errors++; $display("FAIL first_word: got %h@%h want 00000093@00000000", instr_out, pc_out); end
   endtask

   task automatic test_pc4();
      logic [31:0] addr; int waited; bit ok;
      advance(2'b01, 32'h100, $urandom);
      serve_fetch(0, 0, 0, $urandom, 2'b00, addr, waited, ok);
      checks++; if (addr !== 32'h100) begin errors++; $display("FAIL pcimm_addr: got %h want 00000100", addr); end
      advance(2'b00, $urandom, $urandom);
      serve_fetch(0, 0, 0, $urandom, 2'b00, addr, waited, ok);
      checks++; if (addr !== 32'h104) begin errors++; $display("FAIL pc4_addr: got %h want 00000104", addr); end
      checks++; if (pc_out !== 32'h104 || instr_out !== exp_instr || !ok) begin errors++; $display("FAIL pc4_out: got %h@%h ok=%0d want %h@00000104", instr_out, pc_out, ok, exp_instr); end
   endtask

   task automatic test_jalr();
      logic [31:0] addr; int waited; bit ok;
      advance(2'b10, $urandom, 32'h2001);
      serve_fetch(1, 1, 0, $urandom, 2'b00, addr, waited, ok);
      checks++; if (addr !== 32'h2000) begin errors++; $display("FAIL jalr_addr: got %h want 00002000", addr); end
      checks++; if (pc_out !== 32'h2000 || !ok) begin errors++; $display("FAIL jalr_pc: got %h ok=%0d want 00002000", pc_out, ok); end
   endtask

   task automatic test_stall_hold();
      for (int i = 0; i < 5; i++) begin
         pc_write = 1'b0; branch_ctrl = 2'($urandom); pc_imm = $urandom; imm_rs1 = $urandom;
         @(negedge ACLK);
         checks++;
         if (ARVALID !== 1'b0 || IM_stall !== 1'b0 || instr_out !== exp_instr || pc_out !== exp_pc) begin
            errors++;
            $display("FAIL hold_%0d: got arvalid=%b stall=%b %h@%h want 0/0 %h@%h", i, ARVALID, IM_stall, instr_out, pc_out, exp_instr, exp_pc);
         end
      end
   endtask

   task automatic test_slow_error();
      logic [31:0] addr; int waited; bit ok;
      advance(2'b00, $urandom, $urandom);
      serve_fetch(4, 2, 1, 32'hDEAD_BEEF, 2'b10, addr, waited, ok);
      checks++; if (addr !== exp_pc || !ok) begin errors++; $display("FAIL slow_hs: got addr=%h ok=%0d want %h/1", addr, ok, exp_pc); end
      checks++; if (instr_out !== 32'h13 || IM_stall !== 1'b0) begin errors++; $display("FAIL slerr_instr: got %h stall=%b want 00000013/0", instr_out, IM_stall); end
   endtask

   task automatic test_wrap();
      logic [31:0] addr; int waited; bit ok;
      advance(2'b01, 32'hFFFF_FFFC, $urandom);
      serve_fetch(0, 0, 0, $urandom, 2'b00, addr, waited, ok);
      advance(2'b11, $urandom, $urandom);
      serve_fetch(0, 0, 0, $urandom, 2'b00, addr, waited, ok);
      checks++; if (addr !== 32'h0 || pc_out !== 32'h0) begin errors++; $display("FAIL wrap: got addr=%h pc=%h want 00000000", addr, pc_out); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] addr; int waited; bit ok;
      advance(2'b01, 32'h40, $urandom);
      checks++; if (ARVALID !== 1'b1 || ARADDR !== 32'h40) begin errors++; $display("FAIL mid_ar: got valid=%b addr=%h want 1/00000040", ARVALID, ARADDR); end
      ARREADY = 1'b1;
      @(negedge ACLK);
      ARREADY = 1'b0;
      checks++; if (RREADY !== 1'b1) begin errors++; $display("FAIL mid_data: got rready=%b want 1", RREADY); end
      ARESETn = 1'b0;
      @(negedge ACLK);
      checks++;
      if (pc_out !== 32'h0 || ARVALID !== 1'b0 || IM_stall !== 1'b1 || RREADY !== 1'b0 || instr_out !== 32'h13) begin
         errors++;
         $display("FAIL mid_reset: got pc=%h arv=%b stall=%b rr=%b instr=%h", pc_out, ARVALID, IM_stall, RREADY, instr_out);
      end
      ARESETn = 1'b1; exp_pc = 32'h0;
      @(negedge ACLK);
      checks++; if (ARVALID !== 1'b1 || ARADDR !== 32'h0) begin errors++; $display("FAIL mid_restart: got valid=%b addr=%h want 1/00000000", ARVALID, ARADDR); end
      serve_fetch(0, 0, 0, 32'h0000_0093, 2'b00, addr, waited, ok);
      checks++; if (instr_out !== 32'h93 || pc_out !== 32'h0 || !ok) begin errors++; $display("FAIL mid_refetch: got %h@%h ok=%0d want 00000093@00000000", instr_out, pc_out, ok); end
   endtask

   task automatic test_random();
      logic [31:0] addr; int waited; bit ok;
      logic [1:0] bc; logic [31:0] data; logic [1:0] resp;
      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(0, 2)) begin
            branch_ctrl = 2'($urandom);
            @(negedge ACLK);
         end
         bc   = 2'($urandom);
         data = $urandom;
         resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
         advance(bc, $urandom, $urandom);
         serve_fetch($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), data, resp, addr, waited, ok);
         checks++;
         if (addr !== exp_pc || !ok || IM_stall !== 1'b0 || pc_out !== exp_pc || instr_out !== exp_instr) begin
            errors++;
            $display("FAIL rand_%0d: got addr=%h ok=%0d stall=%b %h@%h want %h %h@%h", n, addr, ok, IM_stall, instr_out, pc_out, exp_pc, exp_instr, exp_pc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_pc4();
      test_jalr();
      test_stall_hold();
      test_slow_error();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline.
- Owns the PC and issues one single-beat AXI4 read per instruction to the IM slave.
- Holds the returned word for the IF/ID register and raises IM_stall while a fetch is in flight.
- Consumes PCWrite and BranchCtrl/targets from the hazard/branch logic and computes next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- AXI_ID, 4'h0, constant ARID value; R beats carrying any other RID are discarded.
- NOP_INSTR, 32'h0000_0013, word substituted on an error response.

Ports:
- ACLK  in  1  clock; all state updates on rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- pc_write  in  1  PCWrite from hazard control; 1 = advance PC.
- branch_ctrl  in  2  00 PC4, 01 PCIMM, 10 IMMRS1, 11 reserved (treated as PC4).
- pc_imm  in  32  branch/JAL target.
- imm_rs1  in  32  JALR target before LSB clear.
- instr_out  out  32  fetched instruction to IF/ID.
- pc_out  out  32  address of instr_out.
- IM_stall  out  1  1 while the current instruction is not yet available.
- ARID  out  4  = AXI_ID.
- ARADDR  out  32  = pc.
- ARLEN  out  4  = 0.
- ARSIZE  out  3  = 3'b010.
- ARBURST  out  2  = 2'b01 (INCR).
- ARVALID  out  1  read address valid.
- ARREADY  in  1  read address ready.
- RID  in  4  read data ID.
- RDATA  in  32  read data.
- RRESP  in  2  read response.
- RLAST  in  1  last beat.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.

Behaviour:
- FSM states: S_IDLE, S_REQ, S_DATA, S_HOLD.
- Reset (ARESETn=0 at edge): state=S_IDLE, pc=RESET_PC, instr_buf=NOP_INSTR.
- Outputs during and at reset: ARVALID=0, RREADY=0, IM_stall=1, instr_out=NOP_INSTR, pc_out=RESET_PC.
- Reset mid-transaction abandons it; the slave is reset by the same ARESETn.
- S_IDLE -> S_REQ unconditionally. The first ARVALID appears 1 cycle after reset release.
- S_REQ: ARVALID=1, ARADDR=pc.
  - ARADDR and ARVALID stay stable until ARREADY.
  - On ARVALID&ARREADY -> S_DATA.
- S_DATA: RREADY=1.
  - On RVALID&RLAST&(RID==AXI_ID): capture instr_buf = (RRESP==2'b00) ? RDATA : NOP_INSTR, then -> S_HOLD.
  - Beats with RID!=AXI_ID are accepted and dropped; state stays S_DATA.
- S_HOLD: IM_stall=0, instr_out=instr_buf, pc_out=pc.
  - If pc_write=1: pc<=next_pc, go to S_REQ.
  - Else hold (load-use or DM stall) with no new request.
- IM_stall = (state!=S_HOLD), registered-state decode only. It must not depend combinationally on pc_write or branch_ctrl, so there is no loop through hazard control.
- next_pc:
  - PC4/11 -> pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - PCIMM -> pc_imm.
  - IMMRS1 -> {imm_rs1[31:1],1'b0}.
- Redirect is taken only in S_HOLD with pc_write=1. While IM_stall=1 the EX stage is frozen, so branch_ctrl is ignored outside S_HOLD.
- Minimum fetch latency with zero-wait slave: 2 cycles (S_REQ, S_DATA), giving an instruction every 3 cycles. Back-to-back AR/R overlap is out of scope.
- pc_write=1 outside S_HOLD is ignored; hazard control guarantees it cannot occur.

Decomposition:
- Shared package cpu_pkg:
  - BranchCtrl localparams PC4/PCIMM/IMMRS1.
  - NOP_INSTR.
  - AXI constants: BURST_INCR, SIZE_WORD, RESP_OKAY.
  - Fetch FSM state enum.
- One natural sub-module: pc_next_sel (combinational next-PC mux/adder), reusable by a later branch predictor.

Test Plan:
- Reset release, slave ARREADY=1, RVALID next cycle with RDATA=32'h0000_0093 -> ARADDR=0 on cycle 1; S_HOLD on cycle 3 with instr_out=0x00000093, pc_out=0, IM_stall=0.
- S_HOLD, pc_write=1, branch_ctrl=00, pc=0x100 -> next ARADDR=0x104.
- S_HOLD, pc_write=1, branch_ctrl=10, imm_rs1=0x2001 -> ARADDR=0x2000.
- S_HOLD, pc_write=0 for 5 cycles (load-use/DM stall) -> no ARVALID, instr_out/pc_out unchanged, IM_stall=0.
- ARREADY delayed 4 cycles, then RVALID with RRESP=2'b10 -> ARADDR stable throughout, IM_stall=1 until capture, then instr_out=0x00000013.
- ARESETn=0 while in S_DATA with pc=0x40 -> next cycle pc_out=RESET_PC, ARVALID=0, IM_stall=1; after release, fetch restarts at RESET_PC.
